note_arbiter: RTL and testbench
===============================

Name: note_arbiter

Overview:
Controller in front of the piano tone generator. It synchronises and debounces the five note keys (C4..G4) and arbitrates simultaneous presses with last-pressed priority. It sequences the tone generator through a valid/ready configuration handshake, inserting a muted gap between notes. It also drives the note index consumed by the seven-segment display path.

Parameters:
CLK_MHZ, 100, system clock in MHz; scales the half-period table.
N_KEYS, 5, number of note keys (fixed at 5; the table covers C4..G4).
DB_CYCLES, 1000000, consecutive stable cycles required to accept a key change (10 ms at 100 MHz).
GAP_CYCLES, 50000, muted cycles between successive notes; must be >= 1.
HP_W, 21, width of the half-period word.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
key_raw  input  5  raw key switches, bit0=C4 .. bit4=G4, asynchronous to clk
cfg_ready  input  1  tone generator accepts the half-period word
cfg_valid  output  1  half-period word is presented
cfg_half_period  output  HP_W  toggle count for the tone flip-flop
cfg_enable  output  1  speaker gate; high only while a note plays
active_key  output  3  index of the playing key, 0..4; 7 = none
active_onehot  output  5  one-hot form of active_key; 0 = none

Behaviour:
- Single clock domain on clk. rst_n is asynchronous active-low; every flop clears on assertion.
- Reset values: cfg_valid=0, cfg_half_period=0, cfg_enable=0, active_key=7, active_onehot=0, FSM=IDLE, key_db=0, all counters=0.
- Synchroniser: each key_raw bit passes through 2 flops before the debouncer.
- Debounce, per key:
  - When the synced bit differs from key_db[i], the counter increments.
  - When the counter reaches DB_CYCLES-1 while still differing, key_db[i] takes the synced bit and the counter clears.
  - Any cycle where the synced bit equals key_db[i] clears the counter.
  - Latency from a stable raw edge to the key_db change is 2+DB_CYCLES cycles.
- Press event: rising edge of key_db[i].
- Target selection, evaluated every cycle:
  - A single press event makes that key the target.
  - Multiple press events in the same cycle: the lowest index wins.
  - If the target key's key_db falls, the new target is the lowest-index key still held; if none is held, the target is none.
  - A held non-target key never preempts the current target.
- Half-period table (CLK_MHZ*base): C4=1911, D4=1703, E4=1517, F4=1432, G4=1276. At defaults: 191100, 170300, 151700, 143200, 127600.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: cfg_enable=0. When the target is valid, latch it as play_key and go to LOAD on the next cycle.
  - LOAD: cfg_valid=1 and cfg_half_period=table[play_key], both held stable until cfg_ready. cfg_enable=0. Target changes are ignored while in LOAD. On cfg_valid&&cfg_ready, deassert cfg_valid next cycle and go to PLAY.
  - PLAY: cfg_enable=1, active_key=play_key, active_onehot=1<<play_key. If the target becomes none or differs from play_key, go to GAP.
  - GAP: cfg_enable=0, active_key=7, active_onehot=0. Count GAP_CYCLES cycles. At expiry:
    - target valid: latch it and go to LOAD;
    - target none: go to IDLE.
    - A target that returns to the old key during GAP is still reloaded through LOAD.
- cfg_half_period holds its last value outside LOAD; it is only meaningful while cfg_valid=1.
- active_key and active_onehot are 7 and 0 in every state other than PLAY.
- Reset asserted mid-note: all outputs drop to their reset values immediately (asynchronously). After release, keys still held are re-detected only after 2+DB_CYCLES cycles.
- cfg_ready held high permanently: LOAD lasts exactly 1 cycle.

Test Plan:
Overrides for all tests: DB_CYCLES=8, GAP_CYCLES=4, cfg_ready tied 1 unless stated.
1. Press C4 (key_raw=00001) and hold -> key_db[0] rises 10 cycles later. LOAD for 1 cycle with cfg_half_period=191100. Then cfg_enable=1, active_key=0, active_onehot=00001.
2. Bounce: toggle key_raw[1] every 3 cycles for 30 cycles, then release -> key_db[1] never rises, cfg_valid never asserts, FSM stays IDLE.
3. Hold C4 while playing, then press E4 -> GAP for 4 cycles with cfg_enable=0, then LOAD 151700, PLAY active_key=2. Release E4 -> GAP, then reload C4 (191100).
4. Press D4 and G4 in the same cycle -> D4 (170300, active_key=1) plays. Release D4 -> G4 plays after the gap (127600).
5. Hold cfg_ready=0 for 20 cycles during LOAD -> cfg_valid=1 with cfg_half_period stable throughout and cfg_enable=0. Raise cfg_ready -> PLAY on the next cycle.
6. Assert rst_n=0 in PLAY with F4 held -> cfg_enable=0, active_key=7, cfg_valid=0 immediately. Release rst_n -> F4 (143200) replays after 2+8 cycles plus 1 LOAD cycle.

Source files
------------

// File: rtl/note_arbiter.sv
// note_arbiter: debounces five note keys, picks a target with last-pressed priority,
// and sequences the tone generator through load / play / muted-gap phases.
module note_arbiter #(
  parameter int CLK_MHZ    = 100,
  parameter int N_KEYS     = 5,
  parameter int DB_CYCLES  = 1000000,
  parameter int GAP_CYCLES = 50000,
  parameter int HP_W       = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic              cfg_ready,
  output logic              cfg_valid,
  output logic [HP_W-1:0]   cfg_half_period,
  output logic              cfg_enable,
  output logic [2:0]        active_key,
  output logic [N_KEYS-1:0] active_onehot
);
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [2:0] NONE = 3'd7;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;

  function automatic logic [HP_W-1:0] half_period(input logic [2:0] k);
    half_period = k == 3'd0 ? HP_W'(CLK_MHZ * 1911) :
                  k == 3'd1 ? HP_W'(CLK_MHZ * 1703) :
                  k == 3'd2 ? HP_W'(CLK_MHZ * 1517) :
                  k == 3'd3 ? HP_W'(CLK_MHZ * 1432) :
                  k == 3'd4 ? HP_W'(CLK_MHZ * 1276) : '0;
  endfunction

  function automatic logic [2:0] lowest(input logic [N_KEYS-1:0] v);
    lowest = NONE;
    for (int i = N_KEYS - 1; i >= 0; i--) if (v[i]) lowest = 3'(i);
  endfunction

  logic [N_KEYS-1:0] sync1_q, sync2_q, key_db_q, key_db_d, rise;
  logic [DB_W-1:0]   db_cnt_q [N_KEYS];
  logic [DB_W-1:0]   db_cnt_d [N_KEYS];
  logic [2:0]        target_q, target_d, play_key_q, play_key_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  state_e            state_q, state_d;
  logic              tgt_valid, tgt_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      key_db_q   <= '0;
      for (int i = 0; i < N_KEYS; i++) db_cnt_q[i] <= '0;
      target_q   <= NONE;
      state_q    <= IDLE;
      play_key_q <= '0;
      hp_q       <= '0;
      gap_cnt_q  <= '0;
    end else begin
      sync1_q    <= key_raw;
      sync2_q    <= sync1_q;
      key_db_q   <= key_db_d;
      for (int i = 0; i < N_KEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
      target_q   <= target_d;
      state_q    <= state_d;
      play_key_q <= play_key_d;
      hp_q       <= hp_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    key_db_d = key_db_q;
    for (int i = 0; i < N_KEYS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != key_db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) key_db_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // A fresh press always wins; losing the target falls back to the lowest key still held.
  assign rise      = key_db_d & ~key_db_q;
  assign tgt_valid = target_q != NONE;
  assign tgt_held  = |(key_db_d & (N_KEYS'(1) << target_q));
  assign target_d  = |rise ? lowest(rise) :
                     (tgt_valid && !tgt_held) ? lowest(key_db_d) : target_q;

  always_comb begin
    state_d    = state_q;
    play_key_d = play_key_q;
    hp_d       = hp_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: if (tgt_valid) begin
        state_d    = LOAD;
        play_key_d = target_q;
        hp_d       = half_period(target_q);
      end
      LOAD: if (cfg_ready) state_d = PLAY;
      PLAY: if (target_q != play_key_q) begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d    = tgt_valid ? LOAD : IDLE;
          play_key_d = tgt_valid ? target_q : play_key_q;
          hp_d       = tgt_valid ? half_period(target_q) : hp_q;
        end
      end
    endcase
  end

  assign cfg_valid       = state_q == LOAD;
  assign cfg_enable      = state_q == PLAY;
  assign cfg_half_period = hp_q;
  assign active_key      = cfg_enable ? play_key_q : NONE;
  assign active_onehot   = cfg_enable ? N_KEYS'(1) << play_key_q : '0;
endmodule

// File: tb/tb_note_arbiter.sv
// tb_note_arbiter: directed key scenarios checked against a behavioural model every cycle,
// plus hand-computed literal expectations at key moments.
module tb_note_arbiter;
  localparam int DB  = 8;
  localparam int GAP = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_GAP = 3;

  logic        clk = 0, rst_n = 0, cfg_ready = 1;
  logic [4:0]  key_raw = '0;
  logic        cfg_valid, cfg_enable;
  logic [20:0] cfg_half_period;
  logic [2:0]  active_key;
  logic [4:0]  active_onehot;

  int errors = 0, checks = 0, valid_cycles = 0;
  int tab [5] = '{191100, 170300, 151700, 143200, 127600};
  int m_s1 [5], m_s2 [5], m_db [5], m_run [5];
  int m_tgt, m_phase, m_pk, m_gap, m_hp;

  note_arbiter #(.CLK_MHZ(100), .N_KEYS(5), .DB_CYCLES(DB), .GAP_CYCLES(GAP), .HP_W(21)) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .cfg_ready(cfg_ready),
    .cfg_valid(cfg_valid), .cfg_half_period(cfg_half_period), .cfg_enable(cfg_enable),
    .active_key(active_key), .active_onehot(active_onehot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
    end
    m_tgt = -1; m_phase = P_IDLE; m_pk = 0; m_gap = 0; m_hp = 0;
  endtask

  task automatic model_load();
    m_pk = m_tgt; m_hp = tab[m_tgt]; m_phase = P_LOAD;
  endtask

  // Advance the model by one clock edge using the inputs that edge will sample.
  task automatic model_step();
    int rise_lo;
    case (m_phase)
      P_IDLE: if (m_tgt >= 0) model_load();
      P_LOAD: if (cfg_ready) m_phase = P_PLAY;
      P_PLAY: if (m_tgt != m_pk) begin m_phase = P_GAP; m_gap = GAP; end
      default: begin
        m_gap--;
        if (m_gap == 0) begin
          if (m_tgt >= 0) model_load();
          else m_phase = P_IDLE;
        end
      end
    endcase
    rise_lo = -1;
    for (int i = 0; i < 5; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_db[i] = m_s2[i];
          m_run[i] = 0;
          if (m_db[i] == 1 && rise_lo < 0) rise_lo = i;
        end
      end else m_run[i] = 0;
    end
    if (rise_lo >= 0) m_tgt = rise_lo;
    else if (m_tgt >= 0 && m_db[m_tgt] == 0) begin
      m_tgt = -1;
      for (int i = 4; i >= 0; i--) if (m_db[i] == 1) m_tgt = i;
    end
    for (int i = 0; i < 5; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = int'(key_raw[i]);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("valid", int'(cfg_valid), int'(m_phase == P_LOAD));
      chk("enable", int'(cfg_enable), int'(m_phase == P_PLAY));
      chk("key", int'(active_key), m_phase == P_PLAY ? m_pk : 7);
      chk("onehot", int'(active_onehot), m_phase == P_PLAY ? (1 << m_pk) : 0);
      if (m_phase == P_LOAD) chk("hp", int'(cfg_half_period), m_hp);
      if (cfg_valid) valid_cycles++;
      if (rst_n) model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    tick(2);
    chk("rst_valid", int'(cfg_valid), 0);
    chk("rst_hp", int'(cfg_half_period), 0);
    chk("rst_enable", int'(cfg_enable), 0);
    chk("rst_key", int'(active_key), 7);
    chk("rst_onehot", int'(active_onehot), 0);
    rst_n = 1;
    tick(2);
    // C4 press: debounced after 10 edges, LOAD at 11, PLAY at 12
    key_raw = 5'b00001;
    tick(10);
    chk("t1_not_yet", int'(cfg_valid), 0);
    tick(1);
    chk("t1_valid", int'(cfg_valid), 1);
    chk("t1_hp", int'(cfg_half_period), 191100);
    tick(1);
    chk("t1_enable", int'(cfg_enable), 1);
    chk("t1_key", int'(active_key), 0);
    chk("t1_onehot", int'(active_onehot), 1);
    // E4 preempts the held C4, then C4 returns once E4 is released
    key_raw = 5'b00101;
    tick(11);
    chk("t3_gap_enable", int'(cfg_enable), 0);
    chk("t3_gap_key", int'(active_key), 7);
    tick(4);
    chk("t3_hp_e4", int'(cfg_half_period), 151700);
    tick(1);
    chk("t3_key_e4", int'(active_key), 2);
    key_raw = 5'b00001;
    tick(15);
    chk("t3_hp_c4", int'(cfg_half_period), 191100);
    tick(1);
    chk("t3_key_c4", int'(active_key), 0);
    key_raw = 5'b00000;
    tick(16);
    chk("t3_idle", int'(active_key), 7);
    // bounce on D4 never settles long enough to register
    valid_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      key_raw[1] = ~key_raw[1];
      tick(3);
    end
    key_raw = 5'b00000;
    tick(15);
    chk("t2_no_valid", valid_cycles, 0);
    // D4 and G4 together: D4 first, G4 after D4 is released
    key_raw = 5'b10010;
    tick(11);
    chk("t4_hp_d4", int'(cfg_half_period), 170300);
    tick(1);
    chk("t4_key_d4", int'(active_key), 1);
    key_raw = 5'b10000;
    tick(15);
    chk("t4_hp_g4", int'(cfg_half_period), 127600);
    tick(1);
    chk("t4_onehot_g4", int'(active_onehot), 5'b10000);
    key_raw = 5'b00000;
    tick(16);
    // stalled handshake on F4
    cfg_ready = 0;
    key_raw = 5'b01000;
    tick(11);
    chk("t5_valid0", int'(cfg_valid), 1);
    chk("t5_hp0", int'(cfg_half_period), 143200);
    tick(19);
    chk("t5_valid19", int'(cfg_valid), 1);
    chk("t5_hp19", int'(cfg_half_period), 143200);
    chk("t5_enable19", int'(cfg_enable), 0);
    cfg_ready = 1;
    tick(1);
    chk("t5_play", int'(cfg_enable), 1);
    chk("t5_key", int'(active_key), 3);
    // reset mid-note with F4 still held
    tick(2);
    rst_n = 0;
    #1;
    chk("t6_enable", int'(cfg_enable), 0);
    chk("t6_key", int'(active_key), 7);
    chk("t6_valid", int'(cfg_valid), 0);
    tick(2);
    rst_n = 1;
    tick(10);
    chk("t6_not_yet", int'(cfg_valid), 0);
    tick(1);
    chk("t6_hp", int'(cfg_half_period), 143200);
    tick(1);
    chk("t6_key_f4", int'(active_key), 3);
    key_raw = 5'b00000;
    tick(16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
